// File: rtl/uart_tx_gen2_if.sv
// Write-side handshake between a producer and the UART transmit FIFO.
interface uart_tx_gen2_if #(parameter int DATA_W = 9);
    logic              wr_valid;
    logic              wr_ready;
    logic [DATA_W-1:0] wr_data;

    modport master (output wr_valid, output wr_data, input wr_ready);
    modport slave  (input wr_valid, input wr_data, output wr_ready);
endinterface

// File: rtl/uart_tx_gen2.sv
// UART transmitter with a small write FIFO. Frame format (length, parity, stop bits
// and bit period) is latched when each frame starts.
module uart_tx_gen2 #(
    parameter int DATA_W     = 9,
    parameter int FIFO_DEPTH = 8,
    parameter int DIV_W      = 16
) (
    input  logic                            clk,
    input  logic                            rst,
    uart_tx_gen2_if.slave                   wr,
    input  logic [3:0]                      cfg_len,
    input  logic [1:0]                      cfg_par,
    input  logic                            cfg_stop,
    input  logic [DIV_W-1:0]                cfg_div,
    input  logic                            tx_en,
    output logic                            tx_out,
    output logic                            busy,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_level,
    output logic                            frame_done
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;

    state_e            state_q, state_d;
    logic [DIV_W-1:0]  bcnt_q, bcnt_d, div_q, div_d;
    logic [3:0]        bidx_q, bidx_d, len_q, len_d;
    logic [DATA_W-1:0] sh_q, sh_d;
    logic              par_en_q, par_en_d, par_bit_q, par_bit_d;
    logic              stop2_q, stop2_d, stop_sec_q, stop_sec_d;

    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]     wptr_q, rptr_q;
    logic [LW-1:0]     level_q, level_d;

    logic              push, pop, load, start_ok, bit_end;
    logic [3:0]        len_eff;
    logic [DATA_W-1:0] head, mask;

    assign wr.wr_ready = (level_q != LW'(FIFO_DEPTH));
    assign push        = wr.wr_valid && wr.wr_ready;
    assign fifo_level  = level_q;
    assign busy        = (state_q != IDLE);
    assign head        = mem[rptr_q];
    assign start_ok    = (level_q != '0) && tx_en;
    assign bit_end     = (bcnt_q == div_q);

    // Clamp requested length into 5..DATA_W; parity only covers the bits actually sent.
    always_comb begin
        len_eff = cfg_len;
        if (cfg_len < 4'd5)
            len_eff = 4'd5;
        else if (cfg_len > 4'(DATA_W))
            len_eff = 4'(DATA_W);
        mask = '0;
        for (int i = 0; i < DATA_W; i++)
            mask[i] = (i < int'(len_eff));
    end

    always_comb begin
        state_d    = state_q;
        bcnt_d     = bcnt_q;
        bidx_d     = bidx_q;
        sh_d       = sh_q;
        len_d      = len_q;
        div_d      = div_q;
        par_en_d   = par_en_q;
        par_bit_d  = par_bit_q;
        stop2_d    = stop2_q;
        stop_sec_d = stop_sec_q;
        load       = 1'b0;
        frame_done = 1'b0;
        tx_out     = 1'b1;

        if (state_q != IDLE)
            bcnt_d = bit_end ? '0 : bcnt_q + DIV_W'(1);

        case (state_q)
            IDLE: load = start_ok;
            START: begin
                tx_out = 1'b0;
                if (bit_end) begin
                    state_d = DATA;
                    bidx_d  = '0;
                end
            end
            DATA: begin
                tx_out = sh_q[0];
                if (bit_end) begin
                    sh_d = sh_q >> 1;
                    if (bidx_q == len_q - 4'd1) begin
                        state_d    = par_en_q ? PARITY : STOP;
                        stop_sec_d = 1'b0;
                    end else begin
                        bidx_d = bidx_q + 4'd1;
                    end
                end
            end
            PARITY: begin
                tx_out = par_bit_q;
                if (bit_end) begin
                    state_d    = STOP;
                    stop_sec_d = 1'b0;
                end
            end
            STOP: begin
                if (bit_end) begin
                    if (stop2_q && !stop_sec_q) begin
                        stop_sec_d = 1'b1;
                    end else begin
                        frame_done = 1'b1;
                        state_d    = IDLE;
                        load       = start_ok;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Frame start: pop the head word and snapshot the whole configuration.
        if (load) begin
            state_d   = START;
            bcnt_d    = '0;
            sh_d      = head;
            len_d     = len_eff;
            div_d     = cfg_div;
            par_en_d  = cfg_par[0] ^ cfg_par[1];
            par_bit_d = (^(head & mask)) ^ (cfg_par == 2'b10);
            stop2_d   = cfg_stop;
        end
    end

    assign pop = load;

    always_comb begin
        level_d = level_q;
        if (push && !pop)
            level_d = level_q + LW'(1);
        else if (pop && !push)
            level_d = level_q - LW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst && push)
            mem[wptr_q] <= wr.wr_data;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            bcnt_q     <= '0;
            bidx_q     <= '0;
            sh_q       <= '0;
            len_q      <= 4'd5;
            div_q      <= '0;
            par_en_q   <= 1'b0;
            par_bit_q  <= 1'b0;
            stop2_q    <= 1'b0;
            stop_sec_q <= 1'b0;
            wptr_q     <= '0;
            rptr_q     <= '0;
            level_q    <= '0;
        end else begin
            state_q    <= state_d;
            bcnt_q     <= bcnt_d;
            bidx_q     <= bidx_d;
            sh_q       <= sh_d;
            len_q      <= len_d;
            div_q      <= div_d;
            par_en_q   <= par_en_d;
            par_bit_q  <= par_bit_d;
            stop2_q    <= stop2_d;
            stop_sec_q <= stop_sec_d;
            level_q    <= level_d;
            if (push) wptr_q <= wptr_q + AW'(1);
            if (pop)  rptr_q <= rptr_q + AW'(1);
        end
    end
endmodule

// File: tb/tb_uart_tx_gen2.sv
// Directed bench for uart_tx_gen2: table of single-frame formats plus hand-written
// sequences for FIFO full, reset mid-frame and per-frame divider latching.
module tb_uart_tx_gen2;
    localparam int DATA_W = 9;
    localparam int DEPTH  = 4;
    localparam int DIV_W  = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic [3:0]        cfg_len;
    logic [1:0]        cfg_par;
    logic              cfg_stop;
    logic [DIV_W-1:0]  cfg_div;
    logic              tx_en;
    logic              tx_out, busy, frame_done;
    logic [2:0]        fifo_level;

    uart_tx_gen2_if #(.DATA_W(DATA_W)) wif ();

    uart_tx_gen2 #(.DATA_W(DATA_W), .FIFO_DEPTH(DEPTH), .DIV_W(DIV_W)) dut (
        .clk(clk), .rst(rst), .wr(wif.slave),
        .cfg_len(cfg_len), .cfg_par(cfg_par), .cfg_stop(cfg_stop), .cfg_div(cfg_div),
        .tx_en(tx_en), .tx_out(tx_out), .busy(busy),
        .fifo_level(fifo_level), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  len;
        logic [1:0]  par;
        logic        stop;
        logic [15:0] div;
        logic [8:0]  data;
        logic [15:0] bits;   // bit i = i-th line level, start bit first
        int          flen;   // frame length in clk cycles
    } vec_t;

    vec_t vt [7];
    int   nvec = 0;
    int   nerr = 0;

    task automatic chk(input string name, input int act, input int exp);
        nvec++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic set_cfg(input logic [3:0] l, input logic [1:0] p, input logic s, input logic [15:0] d);
        cfg_len = l; cfg_par = p; cfg_stop = s; cfg_div = d;
    endtask

    task automatic write_one(input logic [8:0] d);
        @(negedge clk);
        wif.wr_valid = 1'b1;
        wif.wr_data  = d;
        @(negedge clk);
        wif.wr_valid = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int bad, nfd, fd_at, blow, per;
        bad = 0; nfd = 0; fd_at = -1; blow = 0;
        per = int'(v.div) + 1;
        @(negedge clk);
        set_cfg(v.len, v.par, v.stop, v.div);
        tx_en = 1'b1;
        write_one(v.data);
        for (int c = 0; c < v.flen; c++) begin
            @(negedge clk);
            if (tx_out !== v.bits[c / per]) bad++;
            if (frame_done) begin nfd++; fd_at = c; end
            if (!busy) blow++;
            if (c == 2) begin
                set_cfg(~v.len, ~v.par, ~v.stop, v.div + 16'd5);
                tx_en = 1'b0;
            end
        end
        @(negedge clk);
        chk($sformatf("v%0d line bits wrong", idx), bad, 0);
        chk($sformatf("v%0d frame_done cycle", idx), fd_at, v.flen - 1);
        chk($sformatf("v%0d frame_done count", idx), nfd, 1);
        chk($sformatf("v%0d busy gaps", idx), blow, 0);
        chk($sformatf("v%0d busy after frame", idx), int'(busy), 0);
        tx_en = 1'b1;
    endtask

    initial begin
        int bad, nfd, nlow, nbusy, fd1, fd2, t40, t47, t48;

        //         len   par    stop  div    data     bits      flen
        vt[0] = '{4'd8,  2'b00, 1'b0, 16'd3, 9'h0A5, 16'h034A, 40};  // 8N1
        vt[1] = '{4'd7,  2'b01, 1'b1, 16'd1, 9'h041, 16'h0682, 22};  // 7E2
        vt[2] = '{4'd9,  2'b10, 1'b0, 16'd2, 9'h1FF, 16'h0BFE, 36};  // 9O1
        vt[3] = '{4'd3,  2'b00, 1'b0, 16'd0, 9'h1F3, 16'h0066, 7};   // len<5 -> 5
        vt[4] = '{4'd15, 2'b11, 1'b1, 16'd1, 9'h155, 16'h0EAA, 24};  // len>9 -> 9, par 11 none
        vt[5] = '{4'd6,  2'b01, 1'b0, 16'd2, 9'h02D, 16'h015A, 27};  // 6E1
        vt[6] = '{4'd5,  2'b10, 1'b1, 16'd0, 9'h007, 16'h018E, 9};   // 5O2

        rst = 1'b0; tx_en = 1'b1; wif.wr_valid = 1'b1; wif.wr_data = 9'h1AB;
        set_cfg(4'd8, 2'b00, 1'b0, 16'd3);
        repeat (3) @(negedge clk);
        chk("reset tx_out", int'(tx_out), 1);
        chk("reset busy", int'(busy), 0);
        chk("reset frame_done", int'(frame_done), 0);
        chk("reset wr_ready", int'(wif.wr_ready), 1);
        chk("reset level (writes ignored)", int'(fifo_level), 0);
        wif.wr_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        chk("idle after reset", int'(busy), 0);

        for (int i = 0; i < 7; i++) run_vec(vt[i], i);

        // FIFO full: fifth word dropped, four frames back-to-back.
        tx_en = 1'b0;
        set_cfg(4'd8, 2'b00, 1'b0, 16'd0);
        for (int i = 0; i < 4; i++) write_one(9'(8'h11 * (i + 1)));
        chk("full wr_ready", int'(wif.wr_ready), 0);
        chk("full level", int'(fifo_level), 4);
        write_one(9'h055);
        chk("drop level", int'(fifo_level), 4);
        tx_en = 1'b1;
        bad = 0; nfd = 0; nlow = 0; nbusy = 0;
        for (int c = 0; c < 45; c++) begin
            @(negedge clk);
            if (c < 40) begin
                int f, b;
                logic [7:0] w;
                f = c / 10; b = c % 10;
                w = 8'(8'h11 * (f + 1));
                if (b == 0 && tx_out === 1'b0) nlow++;
                if (b >= 1 && b <= 8 && tx_out !== w[b-1]) bad++;
                if (busy) nbusy++;
            end else if (busy) bad++;
            if (frame_done) nfd++;
        end
        chk("b2b start bits", nlow, 4);
        chk("b2b data/idle errors", bad, 0);
        chk("b2b busy cycles", nbusy, 40);
        chk("b2b frame_done pulses", nfd, 4);
        chk("b2b level after", int'(fifo_level), 0);

        // Reset while in DATA with two words still queued.
        tx_en = 1'b0;
        set_cfg(4'd8, 2'b00, 1'b0, 16'd3);
        for (int i = 0; i < 3; i++) write_one(9'h0F0 + 9'(i));
        tx_en = 1'b1;
        repeat (10) @(negedge clk);
        chk("pre-reset busy", int'(busy), 1);
        chk("pre-reset level", int'(fifo_level), 2);
        rst = 1'b0; wif.wr_valid = 1'b1; wif.wr_data = 9'h033;
        @(negedge clk);
        chk("midrst tx_out", int'(tx_out), 1);
        chk("midrst busy", int'(busy), 0);
        chk("midrst level", int'(fifo_level), 0);
        chk("midrst wr_ready", int'(wif.wr_ready), 1);
        rst = 1'b1; wif.wr_valid = 1'b0;
        nbusy = 0;
        repeat (20) begin @(negedge clk); if (busy || !tx_out) nbusy++; end
        chk("no frame after reset", nbusy, 0);

        // Divider change mid-frame only affects the following frame.
        tx_en = 1'b0;
        set_cfg(4'd8, 2'b00, 1'b0, 16'd3);
        write_one(9'h0A5);
        write_one(9'h03D);
        tx_en = 1'b1;
        fd1 = -1; fd2 = -1; t40 = -1; t47 = -1; t48 = -1;
        for (int c = 0; c < 126; c++) begin
            @(negedge clk);
            if (c == 5) cfg_div = 16'd7;
            if (frame_done) begin if (fd1 < 0) fd1 = c; else if (fd2 < 0) fd2 = c; end
            if (c == 40) t40 = int'(tx_out);
            if (c == 47) t47 = int'(tx_out);
            if (c == 48) t48 = int'(tx_out);
        end
        chk("div frame1 done", fd1, 39);
        chk("div frame2 done", fd2, 119);
        chk("div frame2 start@40", t40, 0);
        chk("div frame2 start@47", t47, 0);
        chk("div frame2 bit0@48", t48, 1);
        chk("div idle at end", int'(busy), 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
